// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axil_pkg
//  Purpose  : Shared types and constants for the CPU-to-AXI4-Lite bridge and
//             the lane-alignment helper.
//  Contents : size_e (access size), state_e (bridge FSM states),
//             AXI_RESP_OKAY, is_misaligned() helper.
//  Revision : 1.0 - initial release
// ============================================================================
package axil_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WADDR_DATA = 3'd1,
        ST_WRESP      = 3'd2,
        ST_RADDR      = 3'd3,
        ST_RDATA      = 3'd4,
        ST_RESP       = 3'd5
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Raw 2-bit size so that the illegal encoding 3 can be flagged too.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] lane);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return lane[0];
            2'd2:    return |lane;
            default: return 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/axil_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : axil_lane_align
//  Purpose  : Purely combinational byte-lane helper for 32-bit AXI masters.
//             Write side: strobe generation and write-data replication.
//             Read side : right-shift by lane and sign/zero extension.
//  Ports    : wr_size_i/wr_lane_i/wr_data_i -> wr_strb_o/wr_data_o
//             rd_size_i/rd_lane_i/rd_signed_i/rd_data_i -> rd_data_o
//  Revision : 1.0 - initial release
// ============================================================================
module axil_lane_align
    import axil_pkg::*;
(
    input  size_e       wr_size_i,
    input  logic [1:0]  wr_lane_i,
    input  logic [31:0] wr_data_i,
    output logic [3:0]  wr_strb_o,
    output logic [31:0] wr_data_o,
    input  size_e       rd_size_i,
    input  logic [1:0]  rd_lane_i,
    input  logic        rd_signed_i,
    input  logic [31:0] rd_data_i,
    output logic [31:0] rd_data_o
);

    logic [31:0] rd_shifted;

    always_comb begin
        case (wr_size_i)
            SZ_BYTE: begin
                wr_strb_o = 4'b0001 << wr_lane_i;
                wr_data_o = {4{wr_data_i[7:0]}};
            end
            SZ_HALF: begin
                wr_strb_o = 4'b0011 << wr_lane_i;
                wr_data_o = {2{wr_data_i[15:0]}};
            end
            default: begin
                wr_strb_o = 4'b1111;
                wr_data_o = wr_data_i;
            end
        endcase
    end

    assign rd_shifted = rd_data_i >> {rd_lane_i, 3'b000};

    always_comb begin
        case (rd_size_i)
            SZ_BYTE: rd_data_o = {{24{rd_signed_i & rd_shifted[7]}},  rd_shifted[7:0]};
            SZ_HALF: rd_data_o = {{16{rd_signed_i & rd_shifted[15]}}, rd_shifted[15:0]};
            default: rd_data_o = rd_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axil_cpu_master.sv
`default_nettype none
// ============================================================================
//  Module   : axil_cpu_master
//  Purpose  : Converts single CPU load/store requests into one AXI4-Lite
//             read or write transaction each; one request in flight.
//  Ports    : aclk/aresetn        - clock, async active-low reset
//             req_* / rsp_*       - CPU request/response port
//             m_axil_*            - AXI4-Lite master (AW, W, B, AR, R)
//  Revision : 1.0 - initial release
// ============================================================================
module axil_cpu_master
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    generate
        if (DATA_WIDTH != 32) begin : g_bad_width
            $error("axil_cpu_master supports DATA_WIDTH = 32 only");
        end
    endgenerate

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rsp_rdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  awvalid_q, wvalid_q, aw_done_q, w_done_q;
    logic                  bready_q, arvalid_q, rready_q;
    logic                  rsp_valid_q, rsp_error_q, signed_q;
    logic [1:0]            lane_q;
    size_e                 size_q;

    logic [ADDR_WIDTH-1:0] req_addr_aligned;
    logic [3:0]            wr_strb;
    logic [31:0]           wr_data, rd_data;
    logic                  aw_hs, w_hs;

    assign req_addr_aligned = {req_addr[ADDR_WIDTH-1:2], 2'b00};
    assign aw_hs            = awvalid_q & m_axil_awready;
    assign w_hs             = wvalid_q  & m_axil_wready;

    // Write side is fed straight from the request so the lanes can be
    // latched on the accept edge; read side uses the latched request.
    axil_lane_align u_align (
        .wr_size_i   (size_e'(req_size)),
        .wr_lane_i   (req_addr[1:0]),
        .wr_data_i   (req_wdata),
        .wr_strb_o   (wr_strb),
        .wr_data_o   (wr_data),
        .rd_size_i   (size_q),
        .rd_lane_i   (lane_q),
        .rd_signed_i (signed_q),
        .rd_data_i   (m_axil_rdata),
        .rd_data_o   (rd_data)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            lane_q      <= 2'b00;
            size_q      <= SZ_BYTE;
            signed_q    <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        lane_q   <= req_addr[1:0];
                        signed_q <= req_signed;
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            // No bus activity: answer directly with an error.
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            state_q     <= ST_RESP;
                        end else if (req_write) begin
                            size_q    <= size_e'(req_size);
                            awaddr_q  <= req_addr_aligned;
                            wdata_q   <= wr_data;
                            wstrb_q   <= wr_strb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= ST_WADDR_DATA;
                        end else begin
                            size_q    <= size_e'(req_size);
                            araddr_q  <= req_addr_aligned;
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RADDR;
                        end
                    end
                end
                ST_WADDR_DATA: begin
                    // AW and W complete independently in any order.
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (m_axil_bvalid && bready_q) begin
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= (m_axil_bresp != AXI_RESP_OKAY);
                        rsp_rdata_q <= '0;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RADDR: begin
                    if (arvalid_q && m_axil_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (m_axil_rvalid && rready_q) begin
                        // Data is returned even when the slave flags an error.
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= (m_axil_rresp != AXI_RESP_OKAY);
                        rsp_rdata_q <= rd_data;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = (state_q == ST_IDLE);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_error      = rsp_error_q;
    assign m_axil_awaddr  = awaddr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_araddr  = araddr_q;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_cpu_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axil_cpu_master
//  Purpose  : Directed self-checking bench for axil_cpu_master with a small
//             AXI4-Lite memory slave whose ready/response timing is set per
//             test (responses arrive one cycle after the address/data beat,
//             like a registered BRAM).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axil_cpu_master;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
    logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata;
    logic [2:0]  m_axil_awprot, m_axil_arprot;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
    logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
    logic        m_axil_rvalid, m_axil_rready;
    logic [1:0]  m_axil_bresp, m_axil_rresp;

    always #5 clk = ~clk;

    axil_cpu_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .aclk(clk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
        .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // ---------------- slave model ----------------
    logic [31:0] mem [0:255];
    int          aw_delay, w_delay, b_lat, r_lat;
    logic [1:0]  bresp_cfg, rresp_cfg;
    int          aw_wait, w_wait, b_cnt, r_cnt, aw_count, ar_count;
    logic        aw_got, w_got, b_pend, r_pend;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [7:0]  r_idx;
    logic        sm_aw_hs, sm_awv, sm_w_hs, sm_wv, sm_b_hs, sm_ar_hs, sm_r_hs;
    logic [31:0] sm_awaddr, sm_wdata, sm_araddr;
    logic [3:0]  sm_wstrb;

    always @(posedge clk) begin
        // Sample the values the DUT presented for this edge.
        sm_aw_hs  = m_axil_awvalid && m_axil_awready;
        sm_awv    = m_axil_awvalid;
        sm_awaddr = m_axil_awaddr;
        sm_w_hs   = m_axil_wvalid && m_axil_wready;
        sm_wv     = m_axil_wvalid;
        sm_wdata  = m_axil_wdata;
        sm_wstrb  = m_axil_wstrb;
        sm_b_hs   = m_axil_bvalid && m_axil_bready;
        sm_ar_hs  = m_axil_arvalid && m_axil_arready;
        sm_araddr = m_axil_araddr;
        sm_r_hs   = m_axil_rvalid && m_axil_rready;
        #1;
        if (!aresetn) begin
            m_axil_awready = (aw_delay == 0);
            m_axil_wready  = (w_delay == 0);
            m_axil_bvalid  = 1'b0;
            m_axil_rvalid  = 1'b0;
            m_axil_arready = 1'b1;
            aw_wait = 0; w_wait = 0;
            aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
        end else begin
            if (sm_b_hs) m_axil_bvalid = 1'b0;
            if (b_pend) begin
                b_cnt--;
                if (b_cnt == 0) begin
                    m_axil_bvalid = 1'b1;
                    m_axil_bresp  = bresp_cfg;
                    b_pend        = 1'b0;
                end
            end
            if (sm_aw_hs) begin
                s_awaddr = sm_awaddr; aw_got = 1'b1; aw_count++; aw_wait = 0;
                m_axil_awready = (aw_delay == 0);
            end else if (!sm_awv) begin
                aw_wait = 0; m_axil_awready = (aw_delay == 0);
            end else if (!m_axil_awready) begin
                aw_wait++;
                if (aw_wait >= aw_delay) m_axil_awready = 1'b1;
            end
            if (sm_w_hs) begin
                s_wdata = sm_wdata; s_wstrb = sm_wstrb; w_got = 1'b1; w_wait = 0;
                m_axil_wready = (w_delay == 0);
            end else if (!sm_wv) begin
                w_wait = 0; m_axil_wready = (w_delay == 0);
            end else if (!m_axil_wready) begin
                w_wait++;
                if (w_wait >= w_delay) m_axil_wready = 1'b1;
            end
            if (aw_got && w_got) begin
                for (int i = 0; i < 4; i++)
                    if (s_wstrb[i]) mem[s_awaddr[9:2]][8*i +: 8] = s_wdata[8*i +: 8];
                aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1; b_cnt = b_lat;
            end
            if (sm_r_hs) m_axil_rvalid = 1'b0;
            if (r_pend) begin
                r_cnt--;
                if (r_cnt == 0) begin
                    m_axil_rvalid = 1'b1;
                    m_axil_rdata  = mem[r_idx];
                    m_axil_rresp  = rresp_cfg;
                    r_pend        = 1'b0;
                end
            end
            if (sm_ar_hs) begin
                r_idx = sm_araddr[9:2]; ar_count++; r_pend = 1'b1; r_cnt = r_lat;
            end
        end
    end

    int rsp_count = 0;
    always @(posedge clk) if (rsp_valid === 1'b1) rsp_count++;

    // ---------------- write-channel protocol monitor ----------------
    logic mon_en = 1'b0;
    int   viol   = 0;
    logic p_awv = 1'b0, p_aw_hs = 1'b0, p_wv = 1'b0, p_w_hs = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (m_axil_awvalid && m_axil_awaddr !== 32'h0000_0004) viol++;
            if (m_axil_wvalid && (m_axil_wdata !== 32'h0BAD_F00D || m_axil_wstrb !== 4'hF)) viol++;
            if ((m_axil_awvalid || m_axil_wvalid || m_axil_bready) && req_ready) viol++;
            if (p_awv && !m_axil_awvalid && !p_aw_hs) viol++;
            if (p_aw_hs && m_axil_awvalid) viol++;
            if (p_wv && !m_axil_wvalid && !p_w_hs) viol++;
            if (p_w_hs && m_axil_wvalid) viol++;
        end
        p_awv   = m_axil_awvalid;
        p_aw_hs = m_axil_awvalid && m_axil_awready;
        p_wv    = m_axil_wvalid;
        p_w_hs  = m_axil_wvalid && m_axil_wready;
    end

    // ---------------- request driver ----------------
    // lat = 1 means rsp_valid seen in the cycle right after the accept edge.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic err);
        int guard;
        lat = 0; rd = 32'h0; err = 1'b0; guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        rd  = rsp_rdata;
        err = rsp_error;
        @(negedge clk);
        chk("pulse_then_ready", {30'b0, rsp_valid, req_ready}, 32'h1);
    endtask

    // ---------------- directed tests ----------------
    int          lat;
    logic [31:0] rd;
    logic        err;
    int          cnt0, guard;

    initial begin
        aresetn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        aw_delay = 0; w_delay = 0; b_lat = 1; r_lat = 1;
        bresp_cfg = 2'b00; rresp_cfg = 2'b00;
        m_axil_awready = 1'b1; m_axil_wready = 1'b1; m_axil_arready = 1'b1;
        m_axil_bvalid = 1'b0; m_axil_rvalid = 1'b0;
        m_axil_bresp = 2'b00; m_axil_rresp = 2'b00; m_axil_rdata = 32'h0;
        aw_count = 0; ar_count = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ctrl", {25'b0, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid,
                         m_axil_bready, m_axil_rready, rsp_valid, rsp_error}, 32'h0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_axi_regs", m_axil_awaddr | m_axil_araddr | m_axil_wdata | {28'b0, m_axil_wstrb}, 32'h0);
        aresetn = 1'b1;

        // Word store, zero-wait slave
        do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, lat, rd, err);
        chk("sw_awaddr", s_awaddr, 32'h100);
        chk("sw_wstrb", {28'b0, s_wstrb}, 32'hF);
        chk("sw_wdata", s_wdata, 32'hDEAD_BEEF);
        chk("sw_lat", lat, 32'd4);
        chk("sw_err_rd", {rd[30:0], err}, 32'h0);
        chk("prot", {26'b0, m_axil_awprot, m_axil_arprot}, 32'h0);

        // Byte store to lane 3, then read back the word
        do_req(1'b1, 2'd0, 1'b0, 32'h103, 32'h0000_00A5, lat, rd, err);
        chk("sb_awaddr", s_awaddr, 32'h100);
        chk("sb_wstrb", {28'b0, s_wstrb}, 32'h8);
        chk("sb_wdata", s_wdata, 32'hA5A5_A5A5);
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, lat, rd, err);
        chk("lw_data", rd, 32'hA5AD_BEEF);
        chk("lw_lat", lat, 32'd4);
        chk("lw_err", {31'b0, err}, 32'h0);

        // Sub-word loads with extension
        mem[8'h40] = 32'h1280_5634;
        mem[8'h00] = 32'h8001_1234;
        do_req(1'b0, 2'd0, 1'b1, 32'h102, 32'h0, lat, rd, err);
        chk("lb_s_neg", rd, 32'hFFFF_FF80);
        do_req(1'b0, 2'd0, 1'b0, 32'h102, 32'h0, lat, rd, err);
        chk("lb_u", rd, 32'h0000_0080);
        do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, lat, rd, err);
        chk("lb_s_pos", rd, 32'h0000_0012);
        do_req(1'b0, 2'd0, 1'b0, 32'h101, 32'h0, lat, rd, err);
        chk("lb_u_lane1", rd, 32'h0000_0056);
        do_req(1'b0, 2'd1, 1'b1, 32'h002, 32'h0, lat, rd, err);
        chk("lh_s_neg", rd, 32'hFFFF_8001);
        do_req(1'b0, 2'd1, 1'b0, 32'h002, 32'h0, lat, rd, err);
        chk("lh_u", rd, 32'h0000_8001);
        do_req(1'b0, 2'd1, 1'b1, 32'h100, 32'h0, lat, rd, err);
        chk("lh_s_pos", rd, 32'h0000_5634);

        // Misaligned / illegal requests: immediate error, no bus traffic
        cnt0 = ar_count;
        do_req(1'b0, 2'd1, 1'b0, 32'h101, 32'h0, lat, rd, err);
        chk("mis_half_lat", lat, 32'd1);
        chk("mis_half_err_rd", {rd[30:0], err}, 32'h1);
        do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, lat, rd, err);
        chk("mis_sz3_lat", lat, 32'd1);
        chk("mis_sz3_err_rd", {rd[30:0], err}, 32'h1);
        chk("mis_no_ar", ar_count - cnt0, 32'd0);
        cnt0 = aw_count;
        do_req(1'b1, 2'd2, 1'b0, 32'h102, 32'h1111_2222, lat, rd, err);
        chk("mis_word_st", {lat[15:0], 15'b0, err}, {16'd1, 16'd1});
        chk("mis_no_aw", aw_count - cnt0, 32'd0);

        // Slow slave: W ready 3 cycles before AW, late B with SLVERR
        aw_delay = 4; w_delay = 1; b_lat = 6; bresp_cfg = 2'b10;
        viol = 0;
        mon_en = 1'b1;
        do_req(1'b1, 2'd2, 1'b0, 32'h004, 32'h0BAD_F00D, lat, rd, err);
        mon_en = 1'b0;
        chk("slow_protocol", viol, 32'd0);
        chk("slow_err", {31'b0, err}, 32'h1);
        chk("slow_lat", lat, 32'd13);
        chk("slow_mem", mem[8'h01], 32'h0BAD_F00D);
        aw_delay = 0; w_delay = 0; b_lat = 1; bresp_cfg = 2'b00;

        // Reset while waiting in RDATA
        r_lat = 5;
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h100;
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (!m_axil_rready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("rdata_reached", {31'b0, m_axil_rready}, 32'h1);
        cnt0 = rsp_count;
        aresetn = 1'b0;
        #1;
        chk("async_rst", {26'b0, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid,
                          m_axil_bready, m_axil_rready, rsp_valid}, 32'h0);
        repeat (3) @(negedge clk);
        r_lat = 1;
        aresetn = 1'b1;
        repeat (8) @(negedge clk);
        chk("no_rsp_after_abort", rsp_count - cnt0, 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, lat, rd, err);
        chk("post_rst_data", rd, 32'h1280_5634);
        chk("post_rst_lat", lat, 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axil_cpu_master.md
Name: axil_cpu_master

Overview:
Bridges the CPU load/store port to an AXI4-Lite master. It sits directly upstream of the BRAM AXI-Lite slave memory.
Each accepted CPU request becomes exactly one AXI-Lite read or write transaction. Byte strobes and write-data lanes are derived from size and address. Read data is aligned and sign/zero-extended before being returned to the CPU.
One request is outstanding at a time, with no buffering beyond a single request register.

Parameters:
ADDR_WIDTH, 32, width of CPU and AXI addresses
DATA_WIDTH, 32, AXI data width; only 32 is supported (elaboration error otherwise)
STRB_WIDTH, DATA_WIDTH/8, AXI write-strobe width

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
req_valid  in  1  CPU request valid
req_ready  out  1  high only in IDLE; request accepted on req_valid && req_ready
req_write  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
req_signed  in  1  loads only: sign-extend (1) or zero-extend (0)
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  aligned and extended load data; 0 for stores
rsp_error  out  1  valid with rsp_valid; misaligned/illegal request or non-zero resp
m_axil_awaddr/awprot/awvalid/awready  out/out/out/in  ADDR_WIDTH/3/1/1  write address channel
m_axil_wdata/wstrb/wvalid/wready  out/out/out/in  32/STRB_WIDTH/1/1  write data channel
m_axil_bresp/bvalid/bready  in/in/out  2/1/1  write response channel
m_axil_araddr/arprot/arvalid/arready  out/out/out/in  ADDR_WIDTH/3/1/1  read address channel
m_axil_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  read data channel

Behaviour:
- Reset (aresetn = 0, asynchronous):
  - state = IDLE; all *valid, bready, rready, rsp_valid, rsp_error = 0; rsp_rdata = 0; awaddr/araddr/wdata/wstrb = 0.
  - Reset mid-transaction aborts silently: no rsp_valid is emitted and the outstanding AXI beat is dropped.
- Outputs: all are registered except req_ready, which is (state == IDLE). awprot = arprot = 3'b000 always.
- Alignment check at accept:
  - Error if size 1 with addr[0] = 1, size 2 with addr[1:0] != 0, or size 3.
  - On error: no AXI activity, go to RESP with rsp_error = 1 and rsp_rdata = 0.
- Address: AXI address = {req_addr[ADDR_WIDTH-1:2], 2'b00}; byte lane = addr[1:0].
- Write strobe: byte → 4'b0001 << lane; half → 4'b0011 << lane; word → 4'b1111.
- Write data: byte replicated ×4; half replicated ×2; word unchanged.
- FSM states: IDLE, WADDR_DATA, WRESP, RADDR, RDATA, RESP.
- IDLE: on accept, latch the request.
  - Store → WADDR_DATA with awvalid = wvalid = 1 on the next edge.
  - Load → RADDR with arvalid = 1.
- WADDR_DATA: awvalid and wvalid are independent.
  - Each drops the cycle after its own handshake; done flags aw_done and w_done are tracked.
  - When both are done (including the same cycle), go to WRESP with bready = 1.
  - Valids never drop before their handshake; addr/data/strb stay stable while valid.
- WRESP: on bvalid && bready, bready = 0; rsp_error = (bresp != 0); go to RESP.
- RADDR: on arvalid && arready, arvalid = 0, rready = 1, go to RDATA.
- RDATA: on rvalid && rready, rready = 0; go to RESP.
  - Shift rdata right by lane*8.
  - Byte extends bit 7 and half extends bit 15 if req_signed, else zero-extend.
  - rsp_error = (rresp != 0); the data is still returned.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE.
- Latency with a zero-wait slave: accept at cycle 0; rsp_valid at cycle 4 for loads and stores; misaligned requests at cycle 1.
- Back-to-back throughput: req_ready returns on the cycle after the rsp_valid pulse.
- Slave channel ordering: a slave asserting wready before awready, or bvalid early, must be tolerated; bvalid is only sampled in WRESP.

Decomposition:
- Package axil_pkg holds:
  - typedef size_e {SZ_BYTE, SZ_HALF, SZ_WORD};
  - typedef state_e for the FSM states;
  - constant AXI_RESP_OKAY = 2'b00.
- Sub-module axil_lane_align (combinational) holds strobe generation, write-data replication and read extraction/extension. It is shared with future DMA masters.

Test Plan:
- Store word 0xDEADBEEF at 0x100, slave awready/wready high → awaddr 0x100, wstrb 4'hF, wdata 0xDEADBEEF; rsp_valid at cycle 4, rsp_error 0.
- Store byte 0xA5 at 0x103 → awaddr 0x100, wstrb 4'b1000, wdata 0xA5A5A5A5; then a word load at 0x100 on a memory model returns 0xA5xxxxxx.
- Signed byte load at 0x102, memory word 0x12805634 → rsp_rdata 0xFFFFFF80; unsigned gives 0x00000080. Signed half at 0x002 over 0x8001xxxx → 0xFFFF8001.
- Half load at 0x101 → no arvalid ever; rsp_valid at cycle 1 with rsp_error 1 and rsp_rdata 0. Same for req_size 3.
- Store with wready arriving 3 cycles before awready, then bvalid delayed 5 cycles with bresp 2'b10 → valids held stable until each handshake; rsp_error 1; req_ready low throughout.
- Deassert aresetn while in RDATA → all valids and readies 0 immediately; no rsp_valid; after release, a new load completes normally.
